// File: rtl/frame_pair_source.sv
// Temporal-pair source: stores each frame in a RAM and emits the live pixel
// alongside the co-located pixel of the previous frame, in lockstep.
module frame_pair_source #(
    parameter int DATA_WIDTH   = 32,
    parameter int FRAME_PIXELS = 4096,
    parameter int ADDR_WIDTH   = 12
) (
    input  logic                  aclk,
    input  logic                  areset,
    input  logic [DATA_WIDTH-1:0] s_axis_tdata,
    input  logic                  s_axis_tvalid,
    output logic                  s_axis_tready,
    input  logic                  s_axis_tlast,
    input  logic                  s_axis_tuser,
    output logic [DATA_WIDTH-1:0] m_curr_axis_tdata,
    output logic                  m_curr_axis_tvalid,
    output logic                  m_curr_axis_tlast,
    output logic                  m_curr_axis_tuser,
    input  logic                  m_curr_axis_tready,
    output logic [DATA_WIDTH-1:0] m_prev_axis_tdata,
    output logic                  m_prev_axis_tvalid,
    output logic                  m_prev_axis_tlast,
    output logic                  m_prev_axis_tuser,
    input  logic                  m_prev_axis_tready,
    output logic                  prev_valid,
    output logic                  err_sof_early,
    output logic                  err_frame_long,
    output logic [15:0]           frame_cnt
);

    typedef enum logic [1:0] {WAIT_SOF, FIRST, STREAM} state_t;

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(FRAME_PIXELS - 1);

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d, ram_addr;
    logic [DATA_WIDTH-1:0] curr_data_q, curr_data_d, ram_rd_q;
    logic                  curr_last_q, curr_last_d;
    logic                  curr_user_q, curr_user_d;
    logic                  out_valid_q, out_valid_d;
    logic                  prev_valid_q, prev_valid_d;
    logic                  err_early_q, err_early_d;
    logic                  err_long_q, err_long_d;
    logic [15:0]           frame_cnt_q, frame_cnt_d;
    logic                  out_free, accept, load, load_pv, streaming;
    logic [DATA_WIDTH-1:0] mem [FRAME_PIXELS];

    always_comb begin
        out_free      = !out_valid_q || (m_prev_axis_tready && m_curr_axis_tready);
        s_axis_tready = (state_q == WAIT_SOF) || out_free;
        accept        = s_axis_tvalid && s_axis_tready;
        streaming     = (state_q == STREAM);
        state_d       = state_q;
        wr_addr_d     = wr_addr_q;
        curr_data_d   = curr_data_q;
        curr_last_d   = curr_last_q;
        curr_user_d   = curr_user_q;
        out_valid_d   = out_valid_q && !out_free;
        prev_valid_d  = prev_valid_q;
        err_early_d   = 1'b0;
        err_long_d    = 1'b0;
        frame_cnt_d   = frame_cnt_q;
        load          = 1'b0;
        load_pv       = 1'b0;
        ram_addr      = wr_addr_q;
        unique case (state_q)
            WAIT_SOF: begin
                if (accept && out_free && s_axis_tuser) begin
                    load     = 1'b1;
                    ram_addr = '0;
                    state_d  = FIRST;
                end
            end
            default: begin
                if (accept && s_axis_tuser) begin
                    load     = 1'b1;
                    ram_addr = '0;
                    load_pv  = streaming && (wr_addr_q == '0);
                    if (wr_addr_q != '0) begin
                        err_early_d = 1'b1;
                        state_d     = FIRST;
                    end
                end else if (accept && wr_addr_q == '0) begin
                    // A full frame ended and no SOF followed: resync.
                    err_long_d   = 1'b1;
                    state_d      = WAIT_SOF;
                    prev_valid_d = 1'b0;
                end else if (accept) begin
                    load    = 1'b1;
                    load_pv = streaming;
                end
            end
        endcase
        if (load) begin
            out_valid_d  = 1'b1;
            curr_data_d  = s_axis_tdata;
            curr_last_d  = s_axis_tlast;
            curr_user_d  = s_axis_tuser;
            prev_valid_d = load_pv;
            if (ram_addr == LAST_ADDR) begin
                wr_addr_d   = '0;
                frame_cnt_d = frame_cnt_q + 16'd1;
                state_d     = STREAM;
            end else begin
                wr_addr_d = ram_addr + ADDR_WIDTH'(1);
            end
        end
    end

    // Read-before-write, enabled only on a loaded beat so stalls hold the read data.
    always_ff @(posedge aclk) begin
        if (load) begin
            ram_rd_q      <= mem[ram_addr];
            mem[ram_addr] <= s_axis_tdata;
        end
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state_q      <= WAIT_SOF;
            wr_addr_q    <= '0;
            curr_data_q  <= '0;
            curr_last_q  <= 1'b0;
            curr_user_q  <= 1'b0;
            out_valid_q  <= 1'b0;
            prev_valid_q <= 1'b0;
            err_early_q  <= 1'b0;
            err_long_q   <= 1'b0;
            frame_cnt_q  <= '0;
        end else begin
            state_q      <= state_d;
            wr_addr_q    <= wr_addr_d;
            curr_data_q  <= curr_data_d;
            curr_last_q  <= curr_last_d;
            curr_user_q  <= curr_user_d;
            out_valid_q  <= out_valid_d;
            prev_valid_q <= prev_valid_d;
            err_early_q  <= err_early_d;
            err_long_q   <= err_long_d;
            frame_cnt_q  <= frame_cnt_d;
        end
    end

    assign m_curr_axis_tdata  = curr_data_q;
    assign m_curr_axis_tvalid = out_valid_q;
    assign m_curr_axis_tlast  = curr_last_q;
    assign m_curr_axis_tuser  = curr_user_q;
    assign m_prev_axis_tdata  = prev_valid_q ? ram_rd_q : curr_data_q;
    assign m_prev_axis_tvalid = out_valid_q;
    assign m_prev_axis_tlast  = curr_last_q;
    assign m_prev_axis_tuser  = curr_user_q;
    assign prev_valid         = prev_valid_q;
    assign err_sof_early      = err_early_q;
    assign err_frame_long     = err_long_q;
    assign frame_cnt          = frame_cnt_q;

endmodule
